circuito_exp5: RTL and testbench



---
 rtl/circuito_exp5.sv | 182 ++++++++++++++++++
 tb/tb_circuito_exp5.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/circuito_exp5.sv
// circuito_exp5: memory-sequence game top level with 7-segment debug buses.
// Optional macro TIMEOUT_EN enables the ESPERA timeout (TIMEOUT_CYCLES clocks).
module circuito_exp5 #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       sel_nivel,
  input  logic [3:0] chaves,
  output logic       pronto,
  output logic       db_igual,
  output logic       acertou,
  output logic       errou,
  output logic [3:0] leds,
  output logic [6:0] db_timeout,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_estado,
  output logic [6:0] db_jogadafeita,
  output logic [6:0] db_limite,
  output logic       db_tem_jogada,
  output logic       db_endmenorquelimite,
  output logic       db_clock
);
  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARA       = 4'h1,
    INICIA_RODADA = 4'h2,
    ESPERA        = 4'h3,
    REGISTRA      = 4'h4,
    COMPARA       = 4'h5,
    PROXIMA       = 4'h6,
    NOVA_RODADA   = 4'h7,
    ACERTOU       = 4'hA,
    ERROU         = 4'hE
  } state_t;

  // Entry 0 is the least significant nibble.
  localparam logic [63:0] ROM = {4'h4, 4'h1, 4'h8, 4'h8, 4'h4, 4'h4, 4'h2, 4'h2,
                                 4'h1, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1};

  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    case (v)
      4'h0: hex7seg = 7'b1000000;
      4'h1: hex7seg = 7'b1111001;
      4'h2: hex7seg = 7'b0100100;
      4'h3: hex7seg = 7'b0110000;
      4'h4: hex7seg = 7'b0011001;
      4'h5: hex7seg = 7'b0010010;
      4'h6: hex7seg = 7'b0000010;
      4'h7: hex7seg = 7'b1111000;
      4'h8: hex7seg = 7'b0000000;
      4'h9: hex7seg = 7'b0010000;
      4'hA: hex7seg = 7'b0001000;
      4'hB: hex7seg = 7'b0000011;
      4'hC: hex7seg = 7'b1000110;
      4'hD: hex7seg = 7'b0100001;
      4'hE: hex7seg = 7'b0000110;
      default: hex7seg = 7'b0001110;
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [3:0] endereco_q, endereco_d;
  logic [3:0] limite_q, limite_d;
  logic [3:0] jogada_q, jogada_d;
  logic       nivel_q, nivel_d;
  logic       press_q, press_d;
  logic [3:0] memoria;
  logic [3:0] last;
  logic       tem_jogada;
  logic       igual;
  logic       expire;
  logic       tmo;

  assign memoria    = ROM[{endereco_q, 2'b00} +: 4];
  assign tem_jogada = (|chaves) & ~press_q;
  assign igual      = jogada_q == memoria;
  assign last       = nivel_q ? 4'd15 : 4'd7;

`ifdef TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;

  assign expire = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign tmo    = tmo_q;

  always_comb begin
    cnt_d = state_q == ESPERA ? cnt_q + 1'b1 :
            (state_q == INICIA_RODADA || state_q == PROXIMA) ? '0 : cnt_q;
    tmo_d = state_q == PREPARA ? 1'b0 :
            (state_q == ESPERA && !tem_jogada && expire) ? 1'b1 : tmo_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
`else
  assign expire = 1'b0;
  assign tmo    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    endereco_d = endereco_q;
    limite_d   = limite_q;
    jogada_d   = jogada_q;
    nivel_d    = nivel_q;
    press_d    = |chaves;
    case (state_q)
      INICIAL:       state_d = iniciar ? PREPARA : INICIAL;
      PREPARA: begin
        limite_d = 4'd0;
        nivel_d  = sel_nivel;
        state_d  = INICIA_RODADA;
      end
      INICIA_RODADA: begin
        endereco_d = 4'd0;
        state_d    = ESPERA;
      end
      ESPERA:        state_d = tem_jogada ? REGISTRA : expire ? ERROU : ESPERA;
      REGISTRA: begin
        jogada_d = chaves;
        state_d  = COMPARA;
      end
      COMPARA:       state_d = !igual ? ERROU :
                               endereco_q < limite_q ? PROXIMA :
                               limite_q == last ? ACERTOU : NOVA_RODADA;
      PROXIMA: begin
        endereco_d = endereco_q + 4'd1;
        state_d    = ESPERA;
      end
      NOVA_RODADA: begin
        limite_d = limite_q + 4'd1;
        state_d  = INICIA_RODADA;
      end
      ACERTOU, ERROU: state_d = iniciar ? PREPARA : state_q;
      default:        state_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= INICIAL;
      endereco_q <= 4'd0;
      limite_q   <= 4'd0;
      jogada_q   <= 4'd0;
      nivel_q    <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      endereco_q <= endereco_d;
      limite_q   <= limite_d;
      jogada_q   <= jogada_d;
      nivel_q    <= nivel_d;
      press_q    <= press_d;
    end
  end

  assign pronto               = state_q == ACERTOU || state_q == ERROU;
  assign acertou              = state_q == ACERTOU;
  assign errou                = state_q == ERROU;
  assign db_igual             = igual;
  assign leds                 = chaves;
  assign db_timeout           = hex7seg({3'b000, tmo});
  assign db_contagem          = hex7seg(endereco_q);
  assign db_memoria           = hex7seg(memoria);
  assign db_estado            = hex7seg(state_q);
  assign db_jogadafeita       = hex7seg(jogada_q);
  assign db_limite            = hex7seg(limite_q);
  assign db_tem_jogada        = tem_jogada;
  assign db_endmenorquelimite = endereco_q < limite_q;
  assign db_clock             = clock;
endmodule

// File: tb/tb_circuito_exp5.sv
// tb_circuito_exp5: randomized self-checking bench for the memory-sequence game.
`timescale 1ns/1ps
module tb_circuito_exp5;
  localparam int TO = 5000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       sel_nivel = 1'b0;
  logic [3:0] chaves = 4'h0;
  logic       pronto, db_igual, acertou, errou, db_tem_jogada, db_endmenorquelimite, db_clock;
  logic [3:0] leds;
  logic [6:0] db_timeout, db_contagem, db_memoria, db_estado, db_jogadafeita, db_limite;

  int nvec = 0;
  int nerr = 0;

  logic [6:0] seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] seq [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                           4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

  circuito_exp5 #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .sel_nivel(sel_nivel), .chaves(chaves),
    .pronto(pronto), .db_igual(db_igual), .acertou(acertou), .errou(errou), .leds(leds),
    .db_timeout(db_timeout), .db_contagem(db_contagem), .db_memoria(db_memoria),
    .db_estado(db_estado), .db_jogadafeita(db_jogadafeita), .db_limite(db_limite),
    .db_tem_jogada(db_tem_jogada), .db_endmenorquelimite(db_endmenorquelimite),
    .db_clock(db_clock)
  );

  always #5 clock = ~clock;

  task automatic press(input logic [3:0] v, input int hold, input int gap);
    @(negedge clock) chaves = v;
    repeat (hold) @(negedge clock);
    chaves = 4'h0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic start(input logic n);
    @(negedge clock) begin sel_nivel = n; iniciar = 1'b1; end
    @(negedge clock) iniciar = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (10) @(negedge clock);
    reset = 1'b0;
    nvec++; if (db_estado !== seg[0]) begin nerr++; $display("FAIL reset_estado got %b want %b", db_estado, seg[0]); end
    nvec++; if ({pronto, acertou, errou} !== 3'b000) begin nerr++; $display("FAIL reset_status got %b want 000", {pronto, acertou, errou}); end
    nvec++; if (db_limite !== seg[0]) begin nerr++; $display("FAIL reset_limite got %b want %b", db_limite, seg[0]); end
    nvec++; if (db_contagem !== seg[0]) begin nerr++; $display("FAIL reset_contagem got %b want %b", db_contagem, seg[0]); end
    nvec++; if (db_timeout !== seg[0]) begin nerr++; $display("FAIL reset_timeout got %b want %b", db_timeout, seg[0]); end
    chaves = 4'h3;
    #1;
    nvec++; if (leds !== 4'h3) begin nerr++; $display("FAIL leds_echo got %h want 3", leds); end
    nvec++; if (db_tem_jogada !== 1'b1) begin nerr++; $display("FAIL tem_jogada_edge got %b want 1", db_tem_jogada); end
    repeat (4) @(negedge clock);
    nvec++; if (db_tem_jogada !== 1'b0) begin nerr++; $display("FAIL tem_jogada_hold got %b want 0", db_tem_jogada); end
    nvec++; if (db_estado !== seg[0]) begin nerr++; $display("FAIL idle_press_estado got %b want %b", db_estado, seg[0]); end
    nvec++; if (db_jogadafeita !== seg[0]) begin nerr++; $display("FAIL idle_press_jogada got %b want %b", db_jogadafeita, seg[0]); end
    chaves = 4'h0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_full_game(input logic n);
    int last;
    int st, idx, lim;
    last = n ? 15 : 7;
    start(n);
    for (int r = 0; r <= last; r++) begin
      for (int i = 0; i <= r; i++) begin
        press(seq[i], $urandom_range(2, 6), $urandom_range(4, 7));
        if (i < r) begin st = 3; idx = i + 1; lim = r; end
        else if (r == last) begin st = 10; idx = i; lim = r; end
        else begin st = 3; idx = 0; lim = r + 1; end
        nvec++; if (db_estado !== seg[st]) begin nerr++; $display("FAIL game_estado r=%0d i=%0d got %b want %b", r, i, db_estado, seg[st]); end
        nvec++; if (db_contagem !== seg[idx]) begin nerr++; $display("FAIL game_contagem r=%0d i=%0d got %b want %b", r, i, db_contagem, seg[idx]); end
        nvec++; if (db_limite !== seg[lim]) begin nerr++; $display("FAIL game_limite r=%0d i=%0d got %b want %b", r, i, db_limite, seg[lim]); end
        nvec++; if (db_endmenorquelimite !== (idx < lim)) begin nerr++; $display("FAIL game_endmenor r=%0d i=%0d got %b want %b", r, i, db_endmenorquelimite, idx < lim); end
      end
    end
    nvec++; if ({pronto, acertou, errou} !== 3'b110) begin nerr++; $display("FAIL win_status got %b want 110", {pronto, acertou, errou}); end
    nvec++; if (db_igual !== 1'b1) begin nerr++; $display("FAIL win_igual got %b want 1", db_igual); end
    repeat (5) @(negedge clock);
    nvec++; if (acertou !== 1'b1) begin nerr++; $display("FAIL win_hold got %b want 1", acertou); end
  endtask

  task automatic test_restart;
    @(negedge clock) iniciar = 1'b1;
    @(negedge clock) iniciar = 1'b0;
    nvec++; if (db_estado !== seg[1]) begin nerr++; $display("FAIL restart_prepara got %b want %b", db_estado, seg[1]); end
    @(negedge clock);
    nvec++; if (db_estado !== seg[2]) begin nerr++; $display("FAIL restart_inicia got %b want %b", db_estado, seg[2]); end
    @(negedge clock);
    nvec++; if (db_estado !== seg[3]) begin nerr++; $display("FAIL restart_espera got %b want %b", db_estado, seg[3]); end
    nvec++; if (db_limite !== seg[0]) begin nerr++; $display("FAIL restart_limite got %b want %b", db_limite, seg[0]); end
    nvec++; if ({pronto, acertou} !== 2'b00) begin nerr++; $display("FAIL restart_status got %b want 00", {pronto, acertou}); end
  endtask

  task automatic test_wrong_play;
    press(4'h1, 5, 5);
    press(4'h1, 5, 5);
    press(4'h4, 5, 5);
    nvec++; if (db_estado !== seg[14]) begin nerr++; $display("FAIL wrong_estado got %b want %b", db_estado, seg[14]); end
    nvec++; if ({pronto, acertou, errou} !== 3'b101) begin nerr++; $display("FAIL wrong_status got %b want 101", {pronto, acertou, errou}); end
    nvec++; if (db_igual !== 1'b0) begin nerr++; $display("FAIL wrong_igual got %b want 0", db_igual); end
    nvec++; if (db_jogadafeita !== seg[4]) begin nerr++; $display("FAIL wrong_jogada got %b want %b", db_jogadafeita, seg[4]); end
    nvec++; if (db_memoria !== seg[2]) begin nerr++; $display("FAIL wrong_memoria got %b want %b", db_memoria, seg[2]); end
  endtask

  task automatic test_random_errors;
    for (int g = 0; g < 6; g++) begin
      logic n;
      int last, er, ei;
      logic [3:0] bad;
      n = 1'($urandom_range(0, 1));
      last = n ? 15 : 7;
      er = $urandom_range(0, last);
      ei = $urandom_range(0, er);
      do bad = 4'($urandom_range(1, 15)); while (bad == seq[ei]);
      start(n);
      nvec++; if (db_limite !== seg[0]) begin nerr++; $display("FAIL rand_start_limite g=%0d got %b want %b", g, db_limite, seg[0]); end
      for (int r = 0; r <= er; r++) begin
        for (int i = 0; i <= r; i++) begin
          if (r == er && i == ei) break;
          press(seq[i], $urandom_range(2, 6), $urandom_range(4, 7));
          nvec++; if (db_estado !== seg[3]) begin nerr++; $display("FAIL rand_estado g=%0d r=%0d i=%0d got %b want %b", g, r, i, db_estado, seg[3]); end
        end
      end
      press(bad, $urandom_range(2, 6), $urandom_range(4, 7));
      nvec++; if ({pronto, acertou, errou} !== 3'b101) begin nerr++; $display("FAIL rand_err_status g=%0d got %b want 101", g, {pronto, acertou, errou}); end
      nvec++; if (db_jogadafeita !== seg[bad]) begin nerr++; $display("FAIL rand_err_jogada g=%0d got %b want %b", g, db_jogadafeita, seg[bad]); end
      nvec++; if (db_contagem !== seg[ei]) begin nerr++; $display("FAIL rand_err_contagem g=%0d got %b want %b", g, db_contagem, seg[ei]); end
      nvec++; if (db_limite !== seg[er]) begin nerr++; $display("FAIL rand_err_limite g=%0d got %b want %b", g, db_limite, seg[er]); end
    end
  endtask

  task automatic test_timeout;
    start(1'b1);
`ifdef TIMEOUT_EN
    repeat (TO + 20) @(negedge clock);
    nvec++; if (errou !== 1'b1) begin nerr++; $display("FAIL timeout_errou got %b want 1", errou); end
    nvec++; if (db_timeout !== seg[1]) begin nerr++; $display("FAIL timeout_flag got %b want %b", db_timeout, seg[1]); end
    nvec++; if (db_estado !== seg[14]) begin nerr++; $display("FAIL timeout_estado got %b want %b", db_estado, seg[14]); end
    start(1'b0);
    nvec++; if (db_timeout !== seg[0]) begin nerr++; $display("FAIL timeout_clear got %b want %b", db_timeout, seg[0]); end
`else
    repeat (300) @(negedge clock);
    nvec++; if (db_estado !== seg[3]) begin nerr++; $display("FAIL no_timeout_estado got %b want %b", db_estado, seg[3]); end
    nvec++; if (db_timeout !== seg[0]) begin nerr++; $display("FAIL no_timeout_flag got %b want %b", db_timeout, seg[0]); end
    nvec++; if (errou !== 1'b0) begin nerr++; $display("FAIL no_timeout_errou got %b want 0", errou); end
`endif
  endtask

  task automatic test_reset_midgame;
    press(4'h1, 3, 5);
    @(negedge clock) reset = 1'b1;
    @(negedge clock) reset = 1'b0;
    nvec++; if (db_estado !== seg[0]) begin nerr++; $display("FAIL midreset_estado got %b want %b", db_estado, seg[0]); end
    nvec++; if (db_limite !== seg[0]) begin nerr++; $display("FAIL midreset_limite got %b want %b", db_limite, seg[0]); end
  endtask

  initial begin
    test_reset;
    test_full_game(1'b1);
    test_restart;
    test_wrong_play;
    test_full_game(1'b0);
    test_random_errors;
    test_timeout;
    test_reset_midgame;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
